// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and helpers for the PS/2 receiver.
//   frame_state_e : frame-level FSM states
//   BIT_CNT_W     : width of the data-bit counter (8 data bits -> 3 bits)
//   odd_parity_ok : 1 when data bits plus parity bit hold an odd number of ones
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } frame_state_e;

    localparam int unsigned BIT_CNT_W = 3;

    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_rx_if.sv
// ps2_rx_if: consumer-side bus of the PS/2 receiver.
//   rdy   : FIFO not empty
//   data  : show-ahead head of the FIFO
//   level : bytes currently held
//   shift : pulse per accepted falling edge of the filtered PS/2 clock
//   err   : pulse, frame discarded (parity/stop/timeout)
//   ovf   : pulse, good frame dropped because the FIFO was full
//   done  : consumer has taken `data`
// master = receiver side, slave = consumer side.
interface ps2_rx_if #(
    parameter int unsigned DEPTH_LOG2 = 4
);
    logic                  rdy;
    logic [7:0]            data;
    logic [DEPTH_LOG2:0]   level;
    logic                  shift;
    logic                  err;
    logic                  ovf;
    logic                  done;

    modport master (
        output rdy, data, level, shift, err, ovf,
        input  done
    );

    modport slave (
        input  rdy, data, level, shift, err, ovf,
        output done
    );
endinterface

// File: rtl/ps2_fifo.sv
// ps2_fifo: show-ahead byte FIFO of 2**DEPTH_LOG2 entries, all usable.
//   clk, rst (async, active-low)
//   push/wdata : write request; accepted when not full, or when full with a pop
//   pop        : read request; ignored when empty
//   rdata      : head entry (undefined when rdy=0)
//   rdy        : not empty
//   full       : all entries occupied
//   level      : occupancy
// Storage is not reset.
module ps2_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [7:0]          wdata,
    input  logic                pop,
    output logic [7:0]          rdata,
    output logic                rdy,
    output logic                full,
    output logic [DEPTH_LOG2:0] level
);

    localparam int unsigned Depth = 2 ** DEPTH_LOG2;

    logic [7:0]            mem [Depth];
    logic [DEPTH_LOG2:0]   wptr_q, rptr_q;
    logic                  pop_ok, push_ok;

    always_comb begin
        rdy     = (wptr_q != rptr_q);
        // Extra pointer MSB distinguishes full from empty.
        full    = (wptr_q[DEPTH_LOG2] != rptr_q[DEPTH_LOG2]) &&
                  (wptr_q[DEPTH_LOG2-1:0] == rptr_q[DEPTH_LOG2-1:0]);
        level   = wptr_q - rptr_q;
        pop_ok  = pop & rdy;
        push_ok = push & (~full | pop_ok);
        rdata   = mem[rptr_q[DEPTH_LOG2-1:0]];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop_ok)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr_q[DEPTH_LOG2-1:0]] <= wdata;
    end

endmodule

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 serial receiver with glitch filter, frame checking,
// inter-bit timeout and receive FIFO.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   PS2C : PS/2 clock pin (asynchronous)
//   PS2D : PS/2 data pin (asynchronous)
//   bus  : ps2_rx_if.master (rdy, data, level, shift, err, ovf out; done in)
// Build option: define PS2_PARITY_CHECK_EN to enforce odd parity and stop=1;
// otherwise parity/stop are sampled and ignored and err pulses only on timeout.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned FILT_LEN   = 4,
    parameter int unsigned TO_CYCLES  = 2500
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     PS2C,
    input  logic     PS2D,
    ps2_rx_if.master bus
);

    // Pin synchronizers and clock filter
    logic       c_meta_q, c_sync_q, d_meta_q, d_sync_q;
    logic       filt_q;
    logic [3:0] filt_cnt_q;
    logic       shift_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_meta_q   <= 1'b1;
            c_sync_q   <= 1'b1;
            d_meta_q   <= 1'b1;
            d_sync_q   <= 1'b1;
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
            shift_q    <= 1'b0;
        end else begin
            c_meta_q <= PS2C;
            c_sync_q <= c_meta_q;
            d_meta_q <= PS2D;
            d_sync_q <= d_meta_q;
            shift_q  <= 1'b0;
            // Saturating filter: flip only after FILT_LEN consecutive differing samples.
            if (c_sync_q != filt_q) begin
                if (filt_cnt_q == 4'(FILT_LEN - 1)) begin
                    filt_q     <= c_sync_q;
                    filt_cnt_q <= '0;
                    shift_q    <= ~c_sync_q;
                end else begin
                    filt_cnt_q <= filt_cnt_q + 4'd1;
                end
            end else begin
                filt_cnt_q <= '0;
            end
        end
    end

    // Frame FSM, timeout and FIFO push
    frame_state_e         state_q;
    logic [BIT_CNT_W-1:0] bit_cnt_q;
    logic [7:0]           sr_q;
    logic                 par_q;
    logic [15:0]          to_cnt_q;
    logic                 err_q, ovf_q;

    logic                 frame_good;
    logic                 fifo_full, fifo_rdy, pop, push;
    logic [7:0]           fifo_rdata;
    logic [DEPTH_LOG2:0]  fifo_level;

`ifdef PS2_PARITY_CHECK_EN
    // d_sync_q is the stop bit while a shift is seen in STOP.
    assign frame_good = odd_parity_ok(sr_q, par_q) & d_sync_q;
`else
    logic unused_par;
    assign unused_par = par_q;
    assign frame_good = 1'b1;
`endif

    assign pop  = bus.done & fifo_rdy;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign push = shift_q && (state_q == STOP) && frame_good && (!fifo_full || pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            sr_q      <= '0;
            par_q     <= 1'b0;
            to_cnt_q  <= '0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            ovf_q <= 1'b0;
            if (shift_q) begin
                to_cnt_q <= '0;
                case (state_q)
                    IDLE: begin
                        // D=1 on a falling edge is line noise, not a start bit.
                        if (!d_sync_q) begin
                            state_q   <= DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    DATA: begin
                        sr_q      <= {d_sync_q, sr_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == '1) state_q <= PARITY;
                    end
                    PARITY: begin
                        par_q   <= d_sync_q;
                        state_q <= STOP;
                    end
                    STOP: begin
                        state_q <= IDLE;
                        if (!frame_good)              err_q <= 1'b1;
                        else if (fifo_full && !pop)   ovf_q <= 1'b1;
                    end
                    default: state_q <= IDLE;
                endcase
            end else if (state_q != IDLE) begin
                if (to_cnt_q == 16'(TO_CYCLES)) begin
                    state_q  <= IDLE;
                    err_q    <= 1'b1;
                    to_cnt_q <= '0;
                end else begin
                    to_cnt_q <= to_cnt_q + 16'd1;
                end
            end
        end
    end

    ps2_fifo #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .wdata(sr_q),
        .pop  (pop),
        .rdata(fifo_rdata),
        .rdy  (fifo_rdy),
        .full (fifo_full),
        .level(fifo_level)
    );

    assign bus.rdy   = fifo_rdy;
    assign bus.data  = fifo_rdata;
    assign bus.level = fifo_level;
    assign bus.shift = shift_q;
    assign bus.err   = err_q;
    assign bus.ovf   = ovf_q;

endmodule
